stage_reg: RTL and testbench

//  Pipeline register between two CPU stages: latches the packed stage message bus (instr, pc, RS, RT,
//  npc, ext32, AO, WD, tarReg, rtuse, rsuse, tnew, grfWE, branch) once per cycle.

---
 rtl/stage_reg_pkg.sv | 38 +++
 rtl/stage_reg_tnew_dec.sv | 16 +
 rtl/stage_reg.sv | 90 +++++++++
 tb/tb_stage_reg.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/stage_reg_pkg.sv
// Shared message layout for the inter-stage pipeline registers.
// The packed struct below is the single source of truth for field positions.
// The first field in the list occupies the most significant bits of the bus.
package stage_reg_pkg;

  localparam int XLEN   = 32;
  localparam int TNEW_W = 4;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs;
    logic [XLEN-1:0]   rt;
    logic [XLEN-1:0]   npc;
    logic [XLEN-1:0]   ext32;
    logic [XLEN-1:0]   ao;
    logic [XLEN-1:0]   wd;
    logic [REG_W-1:0]  tar_reg;
    logic [TNEW_W-1:0] rtuse;
    logic [TNEW_W-1:0] rsuse;
    logic [TNEW_W-1:0] tnew;
    logic              grf_we;
    logic              branch;
  } msg_t;

  localparam int MSG_W = $bits(msg_t);

  // A bubble is a nop that still carries the pc.
  // Keeping the pc lets exception and debug logic see where the hole came from.
  function automatic msg_t make_bubble(input logic [XLEN-1:0] pc);
    msg_t b;
    b    = '0;
    b.pc = pc;
    return b;
  endfunction

endpackage

// File: rtl/stage_reg_tnew_dec.sv
// Saturating decrementer for the tnew countdown.
// The hazard unit also uses this block.
module tnew_dec
  import stage_reg_pkg::*;
(
  input  logic [TNEW_W-1:0] tnew_in,
  output logic [TNEW_W-1:0] tnew_out
);

  // Stop at zero instead of wrapping around to 15.
  always_comb begin
    tnew_out = tnew_in;
    if (tnew_in != '0) tnew_out = tnew_in - TNEW_W'(1);
  end

endmodule

// File: rtl/stage_reg.sv
// Pipeline register between two CPU stages.
// It supports stall (hold) and flush (bubble), and it counts tnew down as the
// instruction moves forward.
// Optional feature: define PIPE_STAT_EN to add the stall_cnt and bubble_cnt statistics counters.
module stage_reg
  import stage_reg_pkg::*;
#(
  parameter int W        = MSG_W,
  parameter bit DEC_TNEW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     msg_in,
  input  logic             stall,
  input  logic             flush,
  output logic [W-1:0]     msg_out,
  output logic             valid_out,
  output logic             fwd_valid,
  output logic [REG_W-1:0] fwd_reg
`ifdef PIPE_STAT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  msg_t              m_in;
  msg_t              m_load;
  msg_t              m_q;
  logic              valid_q;
  logic [TNEW_W-1:0] tnew_next;

  assign m_in = msg_in;

  tnew_dec u_tnew_dec (
    .tnew_in  (m_in.tnew),
    .tnew_out (tnew_next)
  );

  // Build the value to load: edit tnew, and squash any write to register $0.
  always_comb begin
    m_load = m_in;
    if (DEC_TNEW) m_load.tnew = tnew_next;
    if (m_in.tar_reg == '0) m_load.grf_we = 1'b0;
  end

  // Message register. Priority is reset, then flush, then stall, then load.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q     <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      m_q     <= make_bubble(m_in.pc);
      valid_q <= 1'b0;
    end else if (!stall) begin
      m_q     <= m_load;
      valid_q <= (m_in.instr != '0);
    end
  end

  assign msg_out   = m_q;
  assign valid_out = valid_q;

  // Forwarding info comes only from registered state, so there is no path from msg_in.
  always_comb begin
    fwd_reg   = m_q.tar_reg;
    fwd_valid = m_q.grf_we && (m_q.tar_reg != '0) && (m_q.tnew == '0);
  end

`ifdef PIPE_STAT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Statistics counters. They wrap freely.
  // A stall in the same cycle as a flush counts as a bubble, not a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (flush)      bubble_cnt_q <= bubble_cnt_q + 32'd1;
      else if (stall) stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_stage_reg.sv
// Testbench for stage_reg.
// It drives a table of vectors and checks the results through a scoreboard.
// It also runs hand-written sequences for chaining, DEC_TNEW=0 and reset during a stall.
module tb_stage_reg;
  import stage_reg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, stall0, flush0;
  logic zero_s, zero_f;
  msg_t msg_in0, o0, o1, o2;
  logic v0, v1, v2, fv0, fv1, fv2;
  logic [REG_W-1:0] fr0, fr1, fr2;
`ifdef PIPE_STAT_EN
  logic [31:0] sc0, bc0, sc1, bc1, sc2, bc2;
`endif

  int tests = 0;
  int fails = 0;

  stage_reg #(.W(MSG_W), .DEC_TNEW(1'b1)) u0 (
    .clk(clk), .reset(reset), .msg_in(msg_in0), .stall(stall0), .flush(flush0),
    .msg_out(o0), .valid_out(v0), .fwd_valid(fv0), .fwd_reg(fr0)
`ifdef PIPE_STAT_EN
    , .stall_cnt(sc0), .bubble_cnt(bc0)
`endif
  );

  // Second stage fed by the first, to see tnew keep counting down.
  stage_reg #(.W(MSG_W), .DEC_TNEW(1'b1)) u1 (
    .clk(clk), .reset(reset), .msg_in(o0), .stall(zero_s), .flush(zero_f),
    .msg_out(o1), .valid_out(v1), .fwd_valid(fv1), .fwd_reg(fr1)
`ifdef PIPE_STAT_EN
    , .stall_cnt(sc1), .bubble_cnt(bc1)
`endif
  );

  // F/D-style instance with no tnew decrement.
  stage_reg #(.W(MSG_W), .DEC_TNEW(1'b0)) u2 (
    .clk(clk), .reset(reset), .msg_in(msg_in0), .stall(zero_s), .flush(zero_f),
    .msg_out(o2), .valid_out(v2), .fwd_valid(fv2), .fwd_reg(fr2)
`ifdef PIPE_STAT_EN
    , .stall_cnt(sc2), .bubble_cnt(bc2)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  tar;
    logic        we;
    logic [3:0]  tnew;
    logic        st;
    logic        fl;
    logic [3:0]  e_tnew;
    logic        e_we;
    logic        e_valid;
    logic        e_fwd;
  } vec_t;

  typedef struct {
    msg_t msg;
    logic valid;
    logic fwd;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] tar,
                              input logic we, input logic [3:0] tnew, input logic st, input logic fl,
                              input logic [3:0] e_tnew, input logic e_we, input logic e_valid,
                              input logic e_fwd);
    vec_t v;
    v.instr = instr; v.pc = pc; v.tar = tar; v.we = we; v.tnew = tnew;
    v.st = st; v.fl = fl; v.e_tnew = e_tnew; v.e_we = e_we; v.e_valid = e_valid; v.e_fwd = e_fwd;
    return v;
  endfunction

  function automatic msg_t rand_msg(input vec_t v);
    msg_t m;
    m.instr = v.instr;   m.pc = v.pc;
    m.rs    = $urandom;  m.rt = $urandom;   m.npc = $urandom;
    m.ext32 = $urandom;  m.ao = $urandom;   m.wd  = $urandom;
    m.tar_reg = v.tar;   m.rtuse = 4'($urandom); m.rsuse = 4'($urandom);
    m.tnew  = v.tnew;    m.grf_we = v.we;   m.branch = 1'($urandom);
    return m;
  endfunction

  initial begin
    msg_t m;
    exp_t e, got;

    vt[0]  = mk(32'h00851020, 32'h3000,  2, 1,  2, 0, 0,  1, 1, 1, 0);
    vt[1]  = mk(32'h00851020, 32'h3004,  2, 1,  0, 0, 0,  0, 1, 1, 1);
    vt[2]  = mk(32'h00001234, 32'h3008,  0, 1,  0, 0, 0,  0, 0, 1, 0);
    vt[3]  = mk(32'h00000000, 32'h300c,  5, 1,  1, 0, 0,  0, 1, 0, 1);
    vt[4]  = mk(32'hffffffff, 32'h3010, 31, 0, 15, 0, 0, 14, 0, 1, 0);
    vt[5]  = mk(32'h00000abc, 32'h3014,  7, 1,  1, 0, 0,  0, 1, 1, 1);
    vt[6]  = mk(32'h11111111, 32'h3018,  9, 1,  0, 1, 0,  0, 0, 0, 0);
    vt[7]  = mk(32'h21111111, 32'h301c, 10, 1,  2, 1, 0,  0, 0, 0, 0);
    vt[8]  = mk(32'h31111111, 32'h3020, 11, 0,  5, 1, 0,  0, 0, 0, 0);
    vt[9]  = mk(32'h22222222, 32'h3004,  3, 1,  0, 1, 1,  0, 0, 0, 0);
    vt[10] = mk(32'h33333333, 32'h4000,  4, 1,  0, 0, 1,  0, 0, 0, 0);
    vt[11] = mk(32'h0000008c, 32'h3024,  3, 1,  3, 0, 0,  2, 1, 1, 0);

    zero_s = 1'b0; zero_f = 1'b0;
    stall0 = 1'b0; flush0 = 1'b0;

    // Reset with all-ones on the input bus.
    reset = 1'b1; msg_in0 = '1;
    @(posedge clk); #1;
    chk("reset msg_out", o0, '0);
    chk("reset valid_out", 1'(v0), 1'b0);
    chk("reset fwd_valid", 1'(fv0), 1'b0);
`ifdef PIPE_STAT_EN
    chk("reset stall_cnt", sc0, 32'd0);
    chk("reset bubble_cnt", bc0, 32'd0);
`endif
    reset = 1'b0;

    last_e.msg = '0; last_e.valid = 1'b0; last_e.fwd = 1'b0;

    for (int i = 0; i < 12; i++) begin
      m = rand_msg(vt[i]);
      msg_in0 = m; stall0 = vt[i].st; flush0 = vt[i].fl;
      if (vt[i].fl) begin
        e.msg = '0; e.msg.pc = vt[i].pc; e.valid = 1'b0; e.fwd = 1'b0;
      end else if (vt[i].st) begin
        e = last_e;
      end else begin
        e.msg = m; e.msg.tnew = vt[i].e_tnew; e.msg.grf_we = vt[i].e_we;
        e.valid = vt[i].e_valid; e.fwd = vt[i].e_fwd;
      end
      sb.push_back(e);
      last_e = e;
      @(posedge clk); #1;
      got = sb.pop_front();
      chk($sformatf("vec%0d msg_out", i), o0, got.msg);
      chk($sformatf("vec%0d valid_out", i), 1'(v0), 1'(got.valid));
      chk($sformatf("vec%0d fwd_valid", i), 1'(fv0), 1'(got.fwd));
      chk($sformatf("vec%0d fwd_reg", i), 5'(fr0), 5'(got.msg.tar_reg));
      chk($sformatf("vec%0d nodec tnew", i), 4'(o2.tnew), 4'(vt[i].tnew));
      if (i == 1) begin
        chk("chain tnew", 4'(o1.tnew), 4'd0);
        chk("chain fwd_valid", 1'(fv1), 1'b1);
        chk("chain fwd_reg", 5'(fr1), 5'd2);
      end
`ifdef PIPE_STAT_EN
      if (i == 8) chk("stall_cnt after 3 stalls", sc0, 32'd3);
      if (i == 9) begin
        chk("stall_cnt after stall+flush", sc0, 32'd3);
        chk("bubble_cnt after stall+flush", bc0, 32'd1);
      end
      if (i == 10) chk("bubble_cnt after flush", bc0, 32'd2);
`endif
    end
    stall0 = 1'b0; flush0 = 1'b0;

    // DEC_TNEW=0 instance keeps tnew at 3.
    m = rand_msg(mk(32'h00400020, 32'h5000, 8, 1, 3, 0, 0, 0, 0, 0, 0));
    msg_in0 = m;
    @(posedge clk); #1;
    chk("nodec tnew=3", 4'(o2.tnew), 4'd3);
    chk("dec tnew=3 -> 2", 4'(o0.tnew), 4'd2);

    // Reset arrives during a stall. Reset wins, and the next load is not held.
    stall0 = 1'b1; reset = 1'b1;
    msg_in0 = rand_msg(mk(32'h00000055, 32'h5004, 4, 1, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("reset mid-stall msg_out", o0, '0);
    chk("reset mid-stall valid", 1'(v0), 1'b0);
`ifdef PIPE_STAT_EN
    chk("reset mid-stall stall_cnt", sc0, 32'd0);
`endif
    reset = 1'b0; stall0 = 1'b0;
    m = rand_msg(mk(32'h00000077, 32'h5008, 6, 1, 2, 0, 0, 0, 0, 0, 0));
    msg_in0 = m;
    @(posedge clk); #1;
    chk("post-reset load instr", o0.instr, 32'h77);
    chk("post-reset load tnew", 4'(o0.tnew), 4'd1);
    chk("post-reset load valid", 1'(v0), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
